// File: rtl/e_mdu_pkg.sv
// Shared pipeline definitions for the execute-stage multiply/divide unit.
package e_mdu_pkg;

  localparam int MD_OP_W         = 4;
  localparam int CNT_W           = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_t;

  // True for the multi-cycle ops that occupy the unit and raise busy.
  function automatic logic isLongOp(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_busy_counter.sv
// Down-counter that models multi-cycle latency; busy while the count is nonzero.
// Kept separate so the hazard logic can reuse the same timing model.
module md_busy_counter
  import e_mdu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             busy_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load on a new operation, otherwise count down and stick at zero.
  always_comb begin
    count_d = count_q;
    if (load_en_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_o = (count_q != '0);
  // The edge ending a cycle with count 1 is the one that retires the operation.
  assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: holds HI/LO, computes products and
// quotients up front and commits them after a modelled multi-cycle latency.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_start,
  input  logic [MD_OP_W-1:0] in_op,
  input  logic [31:0]        in_src_a,
  input  logic [31:0]        in_src_b,
  output logic               out_busy,
  output logic               out_start_md,
  output logic [31:0]        out_result
);

  md_op_t      op;
  logic        accept;
  logic        loadMd;
  logic        commit;
  logic        divZero;
  logic        divOvf;
  logic [CNT_W-1:0] loadVal;

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [31:0] divisorS;
  logic [31:0] divisorU;
  logic [31:0] quotS;
  logic [31:0] remS;
  logic [31:0] quotU;
  logic [31:0] remU;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pendHi_q, pendHi_d;
  logic [31:0] pendLo_q, pendLo_d;
  logic        pendWr_q, pendWr_d;

  assign op           = md_op_t'(in_op);
  assign accept       = in_start & ~out_busy;
  assign out_start_md = in_start & isLongOp(op);
  assign loadMd       = accept & isLongOp(op);
  assign loadVal      = ((op == MD_MULT) || (op == MD_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                               : CNT_W'(DIV_CYCLES);

  md_busy_counter u_busy (
    .clk        (clk),
    .reset      (reset),
    .load_en_i  (loadMd),
    .load_val_i (loadVal),
    .busy_o     (out_busy),
    .last_o     (commit)
  );

  // Full-width arithmetic; the divisor is forced to 1 for divide-by-zero and
  // for the signed overflow case, where a/1 already gives the required answer.
  always_comb begin
    prodS    = {{32{in_src_a[31]}}, in_src_a} * {{32{in_src_b[31]}}, in_src_b};
    prodU    = {32'd0, in_src_a} * {32'd0, in_src_b};
    divZero  = (in_src_b == 32'd0);
    divOvf   = (in_src_a == 32'h8000_0000) && (in_src_b == 32'hFFFF_FFFF);
    divisorS = (divZero || divOvf) ? 32'd1 : in_src_b;
    divisorU = divZero ? 32'd1 : in_src_b;
    quotS    = $signed(in_src_a) / $signed(divisorS);
    remS     = $signed(in_src_a) % $signed(divisorS);
    quotU    = in_src_a / divisorU;
    remU     = in_src_a % divisorU;
  end

  // Capture the result of an accepted long op; divide by zero disables commit.
  always_comb begin
    pendHi_d = pendHi_q;
    pendLo_d = pendLo_q;
    pendWr_d = pendWr_q;
    if (loadMd) begin
      unique case (op)
        MD_MULT:  begin pendHi_d = prodS[63:32]; pendLo_d = prodS[31:0]; pendWr_d = 1'b1; end
        MD_MULTU: begin pendHi_d = prodU[63:32]; pendLo_d = prodU[31:0]; pendWr_d = 1'b1; end
        MD_DIV:   begin pendHi_d = remS; pendLo_d = quotS; pendWr_d = ~divZero; end
        MD_DIVU:  begin pendHi_d = remU; pendLo_d = quotU; pendWr_d = ~divZero; end
        default:  ;
      endcase
    end
  end

  // Architectural HI/LO: commit a finished long op, or take a move-to.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit && pendWr_q) begin
      hi_d = pendHi_q;
      lo_d = pendLo_q;
    end else if (accept && (op == MD_MTHI)) begin
      hi_d = in_src_a;
    end else if (accept && (op == MD_MTLO)) begin
      lo_d = in_src_a;
    end
  end

  // State registers; reset clears everything and discards in-flight results.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      pendHi_q <= '0;
      pendLo_q <= '0;
      pendWr_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pendHi_q <= pendHi_d;
      pendLo_q <= pendLo_d;
      pendWr_q <= pendWr_d;
    end
  end

  // Committed HI/LO read for mfhi/mflo; zero for every other op.
  always_comb begin
    out_result = 32'd0;
    if (op == MD_MFHI) begin
      out_result = hi_q;
    end else if (op == MD_MFLO) begin
      out_result = lo_q;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of HI/LO and the busy window.
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_start;
  logic [3:0]  in_op;
  logic [31:0] in_src_a;
  logic [31:0] in_src_b;
  logic        out_busy;
  logic        out_start_md;
  logic [31:0] out_result;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference model state
  logic [31:0] mHi, mLo, mPendHi, mPendLo;
  logic        mPendWr;
  int          mLeft;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_start     (in_start),
    .in_op        (in_op),
    .in_src_a     (in_src_a),
    .in_src_b     (in_src_b),
    .out_busy     (out_busy),
    .out_start_md (out_start_md),
    .out_result   (out_result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Architectural result of a long op, computed with wide plain arithmetic.
  task automatic modelIssue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr, sp;
    logic [63:0] up, w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mPendWr = 1'b1;
    case (op)
      OP_MULT: begin
        sp = sa * sb; w = sp;
        mPendHi = w[63:32]; mPendLo = w[31:0]; mLeft = MULT_N;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        mPendHi = up[63:32]; mPendLo = up[31:0]; mLeft = MULT_N;
      end
      OP_DIV: begin
        mLeft = DIV_N;
        if (b == 32'd0) mPendWr = 1'b0;
        else begin
          sq = sa / sb; sr = sa % sb;
          w = sq; mPendLo = w[31:0];
          w = sr; mPendHi = w[31:0];
        end
      end
      default: begin
        mLeft = DIV_N;
        if (b == 32'd0) mPendWr = 1'b0;
        else begin
          mPendLo = a / b;
          mPendHi = a % b;
        end
      end
    endcase
  endtask

  // One clock cycle: drive, check outputs against the model, then advance it.
  task automatic applyStimulus(input logic rst, input logic start, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expRes;
    @(negedge clk);
    reset = rst; in_start = start; in_op = op; in_src_a = a; in_src_b = b;
    #1;
    expRes = (op == OP_MFHI) ? mHi : (op == OP_MFLO) ? mLo : 32'd0;
    checkOutput("busy", {31'd0, out_busy}, {31'd0, (mLeft > 0)});
    checkOutput("startMd", {31'd0, out_start_md}, {31'd0, (start && op >= OP_MULT && op <= OP_DIVU)});
    checkOutput("result", out_result, expRes);
    @(posedge clk);
    if (rst) begin
      mHi = '0; mLo = '0; mPendHi = '0; mPendLo = '0; mPendWr = 1'b0; mLeft = 0;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0 && mPendWr) begin
        mHi = mPendHi; mLo = mPendLo;
      end
    end else if (start) begin
      if (op >= OP_MULT && op <= OP_DIVU) modelIssue(op, a, b);
      else if (op == OP_MTHI) mHi = a;
      else if (op == OP_MTLO) mLo = a;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] op);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, op, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] pickOperand(input bit zeroBias);
    int sel;
    sel = $urandom_range(0, 9);
    if (zeroBias && sel == 0) return 32'd0;
    case (sel)
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_start = 1'b0; in_op = OP_NONE; in_src_a = '0; in_src_b = '0;
    mHi = '0; mLo = '0; mPendHi = '0; mPendLo = '0; mPendWr = 1'b0; mLeft = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    applyStimulus(1'b1, 1'b0, OP_MFHI, 32'd0, 32'd0);
    checkOutput("rstBusy", {31'd0, out_busy}, 32'd0);
    checkOutput("rstHi", out_result, 32'd0);

    // MULT -2 * 3
    applyStimulus(1'b0, 1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
    checkOutput("multBusy", {31'd0, out_busy}, 32'd1);
    idle(MULT_N, OP_MFHI);
    checkOutput("multHi", out_result, 32'hFFFF_FFFF);
    checkOutput("multDone", {31'd0, out_busy}, 32'd0);
    applyStimulus(1'b0, 1'b0, OP_MFLO, 32'd0, 32'd0);
    checkOutput("multLo", out_result, 32'hFFFF_FFFA);

    // MULTU, with a read of the old HI while busy
    applyStimulus(1'b0, 1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    applyStimulus(1'b0, 1'b0, OP_MFHI, 32'd0, 32'd0);
    checkOutput("multuOldHi", out_result, 32'hFFFF_FFFF);
    checkOutput("multuBusy", {31'd0, out_busy}, 32'd1);
    idle(MULT_N - 1, OP_MFHI);
    checkOutput("multuHi", out_result, 32'h0000_0001);
    applyStimulus(1'b0, 1'b0, OP_MFLO, 32'd0, 32'd0);
    checkOutput("multuLo", out_result, 32'hFFFF_FFFE);

    // DIV -7 / 2, then DIVU by zero leaves HI/LO alone
    applyStimulus(1'b0, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    idle(DIV_N, OP_MFLO);
    checkOutput("divLo", out_result, 32'hFFFF_FFFD);
    applyStimulus(1'b0, 1'b0, OP_MFHI, 32'd0, 32'd0);
    checkOutput("divHi", out_result, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, OP_DIVU, 32'd7, 32'd0);
    idle(DIV_N - 1, OP_MFHI);
    checkOutput("div0Busy", {31'd0, out_busy}, 32'd1);
    idle(1, OP_MFHI);
    checkOutput("div0Hi", out_result, 32'hFFFF_FFFF);
    checkOutput("div0Done", {31'd0, out_busy}, 32'd0);
    applyStimulus(1'b0, 1'b0, OP_MFLO, 32'd0, 32'd0);
    checkOutput("div0Lo", out_result, 32'hFFFF_FFFD);

    // MTHI then MFHI
    applyStimulus(1'b0, 1'b1, OP_MTHI, 32'h1234_5678, 32'd0);
    applyStimulus(1'b0, 1'b0, OP_MFHI, 32'd0, 32'd0);
    checkOutput("mthi", out_result, 32'h1234_5678);

    // MULT issued while busy is ignored
    applyStimulus(1'b0, 1'b1, OP_MULT, 32'd3, 32'd4);
    idle(1, OP_NONE);
    applyStimulus(1'b0, 1'b1, OP_MULT, 32'd5, 32'd6);
    idle(MULT_N - 2, OP_MFLO);
    checkOutput("ignoreLo", out_result, 32'd12);
    checkOutput("ignoreBusy", {31'd0, out_busy}, 32'd0);
    applyStimulus(1'b0, 1'b0, OP_MFHI, 32'd0, 32'd0);
    checkOutput("ignoreHi", out_result, 32'd0);

    // Signed divide overflow
    applyStimulus(1'b0, 1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DIV_N, OP_MFLO);
    checkOutput("ovfLo", out_result, 32'h8000_0000);
    applyStimulus(1'b0, 1'b0, OP_MFHI, 32'd0, 32'd0);
    checkOutput("ovfHi", out_result, 32'd0);

    // Reset during a DIV discards it
    applyStimulus(1'b0, 1'b1, OP_DIV, 32'd100, 32'd3);
    idle(2, OP_MFLO);
    applyStimulus(1'b1, 1'b0, OP_MFLO, 32'd0, 32'd0);
    checkOutput("abortBusy", {31'd0, out_busy}, 32'd0);
    checkOutput("abortLo", out_result, 32'd0);
    idle(DIV_N + 2, OP_MFLO);
    checkOutput("abortNoCommit", out_result, 32'd0);

    // Back-to-back: DIVU accepted the cycle after MULT completes
    applyStimulus(1'b0, 1'b1, OP_MULT, 32'd7, 32'd9);
    idle(MULT_N, OP_NONE);
    applyStimulus(1'b0, 1'b1, OP_DIVU, 32'd100, 32'd7);
    checkOutput("b2bBusy", {31'd0, out_busy}, 32'd1);
    idle(DIV_N, OP_MFLO);
    checkOutput("b2bDone", {31'd0, out_busy}, 32'd0);
    checkOutput("b2bLo", out_result, 32'd14);
    applyStimulus(1'b0, 1'b0, OP_MFHI, 32'd0, 32'd0);
    checkOutput("b2bHi", out_result, 32'd2);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        rst, start;
      logic [3:0]  op;
      rst   = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 3) != 0);
      op    = 4'($urandom_range(0, 8));
      applyStimulus(rst, start, op, pickOperand(1'b0), pickOperand(1'b1));
    end
    idle(DIV_N + 1, OP_MFHI);
    applyStimulus(1'b0, 1'b0, OP_MFLO, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It consumes the operand and instruction fields that the ID/EX pipeline register presents.
- Holds the architectural HI/LO registers.
- Models the MIPS multi-cycle latency of mult/multu/div/divu with a busy counter, so the hazard unit can stall later md-class instructions in D.
- Sits beside the ALU in E. Its read result is muxed into the E result path for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_start  in  1  qualifies in_op for the current E-stage instruction; 0 for bubbles and non-md instructions
- in_op  in  4  md_op_t: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8
- in_src_a  in  32  rs value (already forwarded)
- in_src_b  in  32  rt value (already forwarded)
- out_busy  out  1  multi-cycle operation in flight
- out_start_md  out  1  combinational: in_start & op is MULT/MULTU/DIV/DIVU; used by the hazard unit
- out_result  out  32  combinational: HI when in_op=MFHI, LO when in_op=MFLO, else 0

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, pending HI/LO=0. Reset aborts any in-flight operation and discards its result.
- Accepting an operation: an operation is accepted only when in_start=1 and busy=0.
  - If in_start=1 while busy=1, the command is ignored and no state changes. The hazard unit guarantees this never happens; the bench checks for the ignore.
- Mult/div start in cycle T:
  - The full result is computed from the inputs of cycle T and latched into pending_hi/pending_lo.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy=1 during cycles T+1 .. T+N.
  - On the edge that ends cycle T+N: HI/LO take the pending values, busy drops, counter reaches 0.
  - The new HI/LO are readable in T+N+1. busy=0 in that cycle, so a new start is accepted there. Back-to-back ops have no gap cycle.
- MULT: {HI,LO} = signed 32x32 -> 64 product.
- MULTU: {HI,LO} = unsigned 32x32 -> 64 product.
- DIV:
  - LO = signed quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (div or divu): still busy for DIV_CYCLES; HI/LO are left unchanged at completion.
- MTHI/MTLO with in_start=1 and busy=0: HI (or LO) = in_src_a on that edge. Single cycle, no busy.
- MFHI/MFLO:
  - Pure combinational read of the committed HI/LO. In-flight results are not visible until commit.
  - A read while busy returns the old value; the stall logic prevents that case.
- Counter: 4 bits, decrements by 1 per cycle while nonzero, never wraps below 0. busy = (counter != 0).
- No flush input. E-stage bubbles arrive with in_start=0, and an already-started operation always completes.

Decomposition:
- Shared package (pipeline defs): md_op_t enum, MD_OP_W=4, default latency constants MULT_CYCLES_DEF=5 and DIV_CYCLES_DEF=10.
- The datapath is a single module. The 64-bit product and quotient/remainder are behavioural operators.
- One natural sub-module: md_busy_counter (load value, load enable, busy output), so the stall logic can reuse the same timing model.

Test Plan:
- Reset, then MULT with a=0xFFFFFFFE (-2), b=3 at cycle T -> busy=1 for T+1..T+5; MFHI=0xFFFFFFFF and MFLO=0xFFFFFFFA at T+6; busy=0.
- MULTU with a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles; MFHI during busy still returns the previous HI.
- DIV with a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with a=7, b=0 -> busy 10 cycles, HI/LO unchanged.
- MTHI with a=0x12345678, then MFHI next cycle -> 0x12345678. A MULT issued while busy -> ignored, and HI/LO match the first op only.
- Reset asserted at cycle T+3 of a DIV -> busy=0, HI=LO=0 on the next cycle; the pending result never commits.
- Back-to-back: MULT completes at T+5 and DIVU is issued at T+6 -> accepted, busy=1 for T+7..T+16.
